// File: rtl/cache_miss_ctrl.sv
// Miss controller for a 4-way set-associative L1: serves hits, latches the victim on a miss,
// and runs the optional dirty writeback followed by the line fill over the pmem handshake.
module cache_miss_ctrl #(
    parameter int unsigned TAG_W    = 9,
    parameter int unsigned SET_W    = 3,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [TAG_W+SET_W+OFFSET_W-1:0]   mem_address,
    input  logic [3:0]                        hit,
    input  logic [3:0]                        valid,
    input  logic [3:0]                        dirty,
    input  logic [4*TAG_W-1:0]                way_tags,
    input  logic [1:0]                        replace_way,
    input  logic                              pmem_resp,
    output logic                              mem_resp,
    output logic                              pmem_read,
    output logic                              pmem_write,
    output logic [TAG_W+SET_W+OFFSET_W-1:0]   pmem_address,
    output logic [3:0]                        load_way,
    output logic [3:0]                        set_dirty,
    output logic [3:0]                        clear_dirty,
    output logic [3:0]                        lru_way
);

    localparam int unsigned ADDR_W = TAG_W + SET_W + OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_victim;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rst_q;

    logic                w_req;
    logic                w_block;
    logic                w_latch;
    logic                w_victim_wb;
    logic [3:0]          w_hit_oh;
    logic [3:0]          w_victim_oh;
    logic [TAG_W-1:0]    w_victim_tag;
    logic [SET_W-1:0]    w_set;
    logic                w_unused_offset;

    assign w_req           = mem_read | mem_write;
    assign w_block         = reset | r_rst_q;
    assign w_hit_oh        = hit & (~hit + 4'd1);
    assign w_victim_oh     = 4'b0001 << r_victim;
    assign w_victim_wb     = valid[replace_way] & dirty[replace_way];
    assign w_set           = r_addr[OFFSET_W +: SET_W];
    assign w_unused_offset = ^r_addr[OFFSET_W-1:0];

    // Stored tag of the latched victim way, used to form the writeback address
    always_comb begin
        w_victim_tag = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_victim == 2'(i)) begin
                w_victim_tag = way_tags[i*TAG_W +: TAG_W];
            end
        end
    end

    // State, victim and miss address registers; r_rst_q masks the cycle after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_victim <= 2'd0;
            r_addr   <= '0;
            r_rst_q  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_rst_q <= 1'b0;
            if (w_latch) begin
                r_victim <= replace_way;
                r_addr   <= mem_address;
            end
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        load_way     = 4'b0000;
        set_dirty    = 4'b0000;
        clear_dirty  = 4'b0000;
        lru_way      = 4'b0000;
        if (!w_block) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (|hit) begin
                            mem_resp = 1'b1;
                            lru_way  = w_hit_oh;
                            if (mem_write) begin
                                set_dirty = w_hit_oh;
                            end
                        end else begin
                            w_latch      = 1'b1;
                            w_next_state = w_victim_wb ? S_WRITEBACK : S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {w_victim_tag, w_set, {OFFSET_W{1'b0}}};
                    if (pmem_resp) begin
                        clear_dirty  = w_victim_oh;
                        w_next_state = S_FILL;
                    end
                end
                S_FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    if (pmem_resp) begin
                        load_way     = w_victim_oh;
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: hit vector table, directed miss/reset sequences
// and randomized transactions checked against a transaction-level expectation model.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [3:0]  hit;
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [35:0] way_tags;
    logic [1:0]  replace_way;
    logic        pmem_resp;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [3:0]  load_way;
    logic [3:0]  set_dirty;
    logic [3:0]  clear_dirty;
    logic [3:0]  lru_way;

    int n_checks = 0;
    int n_fail   = 0;

    cache_miss_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .hit          (hit),
        .valid        (valid),
        .dirty        (dirty),
        .way_tags     (way_tags),
        .replace_way  (replace_way),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .load_way     (load_way),
        .set_dirty    (set_dirty),
        .clear_dirty  (clear_dirty),
        .lru_way      (lru_way)
    );

    always #5 clk = ~clk;

    // Observation vector: {mem_resp, pmem_read, pmem_write, pmem_address, load, set_d, clr_d, lru}
    function automatic logic [34:0] mk(input logic resp, input logic prd, input logic pwr,
                                       input logic [15:0] pa, input logic [3:0] ld,
                                       input logic [3:0] sd, input logic [3:0] cd,
                                       input logic [3:0] lru);
        return {resp, prd, pwr, pa, ld, sd, cd, lru};
    endfunction

    localparam logic [34:0] ZERO = 35'd0;

    // Compare outputs 1ns after inputs settle, then advance to 2ns past the next rising edge
    task automatic step(input string name, input logic [34:0] exp);
        logic [34:0] got;
        #1;
        got = {mem_resp, pmem_read, pmem_write, pmem_address, load_way, set_dirty,
               clear_dirty, lru_way};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 4'b0000;
        pmem_resp = 1'b0;
    endtask

    function automatic logic [3:0] lowest_onehot(input logic [3:0] h);
        for (int i = 0; i < 4; i++) begin
            if (h[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    // Full miss transaction: miss cycle, optional writeback, fill, then the hit that completes it
    task automatic miss_txn(input string name, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [1:0] rw,
                            input logic [3:0] v, input logic [3:0] d, input logic [35:0] tags,
                            input int lat_wb, input int lat_fill, input bit jitter,
                            input bit drop);
        logic        wb;
        logic [3:0]  oh;
        logic [8:0]  vtag;
        logic [15:0] pa;
        wb   = v[rw] & d[rw];
        oh   = 4'(1 << rw);
        vtag = tags[int'(rw)*9 +: 9];
        idle_in();
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        valid       = v;
        dirty       = d;
        way_tags    = tags;
        replace_way = rw;
        step({name, "_miss"}, ZERO);
        if (drop) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        if (wb) begin
            pa = {vtag, addr[6:4], 4'h0};
            for (int k = 0; k <= lat_wb; k++) begin
                pmem_resp = (k == lat_wb);
                if (jitter) begin
                    replace_way = 2'($urandom);
                    mem_address = 16'($urandom);
                end
                step({name, "_wb"}, mk(1'b0, 1'b0, 1'b1, pa, 4'b0, 4'b0,
                                       (k == lat_wb) ? oh : 4'b0, 4'b0));
            end
        end
        pa = {addr[15:4], 4'h0};
        for (int k = 0; k <= lat_fill; k++) begin
            pmem_resp = (k == lat_fill);
            if (jitter) begin
                replace_way = 2'($urandom);
                mem_address = 16'($urandom);
            end
            step({name, "_fill"}, mk(1'b0, 1'b1, 1'b0, pa, (k == lat_fill) ? oh : 4'b0,
                                     4'b0, 4'b0, 4'b0));
        end
        pmem_resp   = 1'b0;
        mem_address = addr;
        replace_way = rw;
        hit         = oh;
        if (drop) begin
            step({name, "_nodone"}, ZERO);
        end else begin
            step({name, "_done"}, mk(1'b1, 1'b0, 1'b0, 16'h0, 4'b0, wr ? oh : 4'b0,
                                     4'b0, oh));
        end
        idle_in();
        step({name, "_quiet"}, ZERO);
    endtask

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [3:0] hit;
        logic       exp_resp;
        logic [3:0] exp_sd;
        logic [3:0] exp_lru;
    } hit_vec_t;

    hit_vec_t vecs[7];

    initial begin
        vecs[0] = '{"rd_hit_w2",    1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0100};
        vecs[1] = '{"wr_hit_w0",    1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001};
        vecs[2] = '{"rd_multi_hit", 1'b1, 1'b0, 4'b0110, 1'b1, 4'b0000, 4'b0010};
        vecs[3] = '{"rdwr_hit_w3",  1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 4'b1000};
        vecs[4] = '{"noreq_hit",    1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000};
        vecs[5] = '{"wr_multi_hit", 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0100, 4'b0100};
        vecs[6] = '{"rd_all_hit",   1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0001};

        idle_in();
        mem_address = 16'h0;
        valid       = 4'h0;
        dirty       = 4'h0;
        way_tags    = 36'h0;
        replace_way = 2'd0;

        // Reset cycle and the following cycle stay silent even with a hit pending
        @(posedge clk);
        #2;
        reset    = 1'b1;
        mem_read = 1'b1;
        hit      = 4'b0010;
        step("reset_cycle", ZERO);
        reset = 1'b0;
        step("post_reset_cycle", ZERO);
        step("first_hit", mk(1'b1, 1'b0, 1'b0, 16'h0, 4'b0, 4'b0, 4'b0, 4'b0010));

        for (int i = 0; i < 7; i++) begin
            idle_in();
            mem_read  = vecs[i].rd;
            mem_write = vecs[i].wr;
            hit       = vecs[i].hit;
            step(vecs[i].name, mk(vecs[i].exp_resp, 1'b0, 1'b0, 16'h0, 4'b0,
                                  vecs[i].exp_sd, 4'b0, vecs[i].exp_lru));
        end

        // pmem_resp while idle is ignored
        idle_in();
        pmem_resp = 1'b1;
        step("idle_pmem_resp", ZERO);

        miss_txn("clean_miss", 1'b1, 1'b0, 16'h1234, 2'd3, 4'b0000, 4'b0000, 36'h0,
                 0, 0, 1'b0, 1'b0);
        miss_txn("dirty_miss", 1'b1, 1'b0, {9'h0A0, 3'd3, 4'h5}, 2'd1, 4'b1111, 4'b0010,
                 {9'h1AA, 9'h0F0, 9'h055, 9'h001}, 1, 2, 1'b0, 1'b0);
        miss_txn("fill_jitter", 1'b0, 1'b1, 16'hBEEF, 2'd2, 4'b1011, 4'b1111,
                 36'h123456789, 0, 3, 1'b1, 1'b0);
        miss_txn("invalid_dirty", 1'b1, 1'b0, 16'h7A3C, 2'd0, 4'b1110, 4'b1111,
                 36'hFFFFFFFFF, 0, 1, 1'b0, 1'b0);
        miss_txn("req_drop", 1'b0, 1'b1, 16'h4321, 2'd2, 4'b0100, 4'b0100,
                 36'h0ABCDEF01, 2, 1, 1'b1, 1'b1);

        // Reset while a writeback is in flight
        idle_in();
        mem_read    = 1'b1;
        mem_address = 16'h5670;
        valid       = 4'b1111;
        dirty       = 4'b1111;
        way_tags    = {9'h111, 9'h0C3, 9'h022, 9'h011};
        replace_way = 2'd2;
        step("rst_wb_miss", ZERO);
        step("rst_wb_active", mk(1'b0, 1'b0, 1'b1, {9'h0C3, 3'd7, 4'h0}, 4'b0, 4'b0,
                                 4'b0, 4'b0));
        reset     = 1'b1;
        pmem_resp = 1'b1;
        step("rst_wb_reset", ZERO);
        idle_in();
        step("rst_wb_after", ZERO);
        mem_read = 1'b1;
        hit      = 4'b0100;
        step("rst_wb_rehit", mk(1'b1, 1'b0, 1'b0, 16'h0, 4'b0, 4'b0, 4'b0, 4'b0100));
        idle_in();
        step("rst_wb_idle", ZERO);

        // Randomized mix of hits and full miss transactions
        for (int t = 0; t < 60; t++) begin
            logic        rd;
            logic        wr;
            logic [3:0]  h;
            logic [3:0]  oh;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
                idle_in();
                h           = 4'($urandom_range(1, 15));
                oh          = lowest_onehot(h);
                mem_read    = rd;
                mem_write   = wr;
                mem_address = 16'($urandom);
                hit         = h;
                step("rand_hit", mk(1'b1, 1'b0, 1'b0, 16'h0, 4'b0, wr ? oh : 4'b0,
                                    4'b0, oh));
            end else begin
                miss_txn("rand_miss", rd, wr, 16'($urandom), 2'($urandom), 4'($urandom),
                         4'($urandom), {4'($urandom), 32'($urandom)},
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom), ($urandom_range(0, 7) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
